// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, the NOP word and the PC increment.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a
// time, holds the fetched word for decode and squashes stale fetches.
// Ports: clk, rst (async, active-high); imem_req_* request channel;
// imem_rsp_* in-order response; redirect_* from execute; inst_* to
// decode; fetch_misaligned flag.
// Optional: FETCH_MISALIGN_CHECK_EN turns a redirect with nonzero
// low bits into a flagged NOP held in OUT instead of a fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    output logic        fetch_misaligned
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         drop_q, drop_d;
    logic         mis_q, mis_d;
    logic         req_valid;
    logic         mis_redir;
    logic [31:0]  redir_al;

    assign redir_al = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    assign mis_redir        = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_misaligned = mis_q;
`else
    logic unused_lo;
    assign unused_lo        = ^redirect_pc[1:0];
    assign mis_redir        = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        ipc_d     = ipc_q;
        mis_d     = mis_q;
        req_valid = 1'b0;
        unique case (state_q)
            REQ: begin
                // A stale response may still be in flight after a
                // misaligned trap; hold off until it has drained.
                if (drop_q) begin
                    if (imem_rsp_valid) drop_d = 1'b0;
                end else if (!mis_redir) begin
                    req_valid = 1'b1;
                end
                if (redirect_valid) begin
                    pc_d  = redir_al;
                    mis_d = 1'b0;
                    if (req_valid && imem_req_ready) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (req_valid && imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d  = redir_al;
                    mis_d = 1'b0;
                    if (imem_rsp_valid) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d  = imem_rsp_data;
                        ipc_d   = pc_q;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (drop_q && imem_rsp_valid) drop_d = 1'b0;
                // Redirect wins over the sequential increment.
                if (redirect_valid) begin
                    pc_d    = redir_al;
                    mis_d   = 1'b0;
                    state_d = REQ;
                end else if (inst_ready && !mis_q) begin
                    pc_d    = pc_q + PC_INC;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        // Misaligned target: present a flagged NOP instead of fetching.
        if (mis_redir) begin
            state_d = OUT;
            inst_d  = NOP_INSN;
            ipc_d   = redirect_pc;
            mis_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            inst_q  <= NOP_INSN;
            ipc_q   <= RESET_PC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_req_valid = req_valid && !rst;
    assign imem_req_addr  = {pc_q[31:2], 2'b00};
    assign inst_valid     = (state_q == OUT);
    assign inst           = inst_q;
    assign inst_pc        = ipc_q;
    assign inst_pc_plus4  = ipc_q + PC_INC;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit.
// Memory model answers requests; expected fetches and outputs are queued.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        fetch_misaligned;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_pc_plus4    (inst_pc_plus4),
        .fetch_misaligned (fetch_misaligned)
    );

    localparam logic [31:0] D = 32'h0050_0093;

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;
    int cyc    = 0;
    int last_hs = -1;
    bit rate_chk = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_inst_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'h10)  return 32'hDEAD_BEEF;
        if (a == 32'h200) return 32'h1234_5678;
        return D;
    endfunction

    function automatic int mem_lat(logic [31:0] a);
        return (a == 32'h10) ? 3 : 1;
    endfunction

    // Memory model: accept decided at negedge, response driven after edge.
    initial begin
        bit          acc;
        bit          pend;
        int          cnt;
        logic [31:0] ma;
        logic [31:0] ea;
        pend = 0;
        cnt = 0;
        ma = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc = !rst && imem_req_valid && imem_req_ready;
            if (acc) begin
                ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front()
                                               : 32'hxxxx_xxxx;
                chk("req_addr", imem_req_addr, ea);
                ma = imem_req_addr;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (acc) begin
                pend = 1;
                cnt  = mem_lat(ma);
            end
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(ma);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Output monitor: a consumed instruction is popped and compared.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && inst_valid && inst_ready && !redirect_valid
            && !fetch_misaligned) begin
            e = (exp_inst_q.size() != 0) ? exp_inst_q.pop_front()
                                         : 64'hxxxx_xxxx_xxxx_xxxx;
            chk("inst", inst, e[63:32]);
            chk("inst_pc", inst_pc, e[31:0]);
            chk("inst_pc_plus4", inst_pc_plus4, e[31:0] + 32'd4);
            if (rate_chk && last_hs >= 0)
                chk("rate", cyc - last_hs, 3);
            last_hs = cyc;
            n_out++;
        end
    end

    task automatic push_inst(logic [31:0] pc);
        exp_inst_q.push_back({mem_word(pc), pc});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_nout(int target);
        int k = 0;
        while (n_out < target && k < 60) begin
            step();
            k++;
        end
        chk("wait_nout", n_out, target);
    endtask

    task automatic wait_valid();
        int k = 0;
        @(negedge clk);
        while (!inst_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("wait_valid", inst_valid, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h13);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_pc_plus4", inst_pc_plus4, 32'h4);
        chk("rst_misaligned", fetch_misaligned, 1'b0);

        // Sequential stream 0, 4, 8 with decode always ready.
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            push_inst(32'(i * 4));
        end
        rate_chk = 1;
        step();
        rst = 1'b0;
        wait_nout(3);
        imem_req_ready = 1'b0;
        rate_chk = 0;

        // Decode stall in OUT at pc 0xC.
        exp_addr_q.push_back(32'hC);
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", inst_valid, 1'b1);
            chk("stall_inst", inst, D);
            chk("stall_pc", inst_pc, 32'hC);
            chk("stall_noreq", imem_req_valid, 1'b0);
        end

        // Release, then redirect while 0x10 is outstanding.
        step();
        push_inst(32'hC);
        exp_addr_q.push_back(32'h10);
        exp_addr_q.push_back(32'h100);
        push_inst(32'h100);
        inst_ready = 1'b1;
        wait_nout(4);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wait_drop_noreq", imem_req_valid, 1'b0);
        chk("wait_drop_novalid", inst_valid, 1'b0);
        wait_nout(5);
        imem_req_ready = 1'b0;

        // Redirect to 0x200 together with inst_ready at pc 0x40.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        exp_addr_q.push_back(32'h40);
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        wait_valid();
        chk("out40_pc", inst_pc, 32'h40);
        step();
        exp_addr_q.push_back(32'h200);
        push_inst(32'h200);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_valid_drop", inst_valid, 1'b0);
        chk("redir_addr", imem_req_addr, 32'h200);
        wait_nout(6);
        imem_req_ready = 1'b0;

        // Wrap-around at the top of the address space.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        push_inst(32'hFFFF_FFFC);
        push_inst(32'h0);
        imem_req_ready = 1'b1;
        wait_valid();
        chk("wrap_plus4", inst_pc_plus4, 32'h0);
        wait_nout(8);
        imem_req_ready = 1'b0;

        // Misaligned redirect target 0x102.
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_valid", inst_valid, 1'b1);
            chk("mis_flag", fetch_misaligned, 1'b1);
            chk("mis_pc", inst_pc, 32'h102);
            chk("mis_inst", inst, 32'h13);
            chk("mis_noreq", imem_req_valid, 1'b0);
        end
        step();
        exp_addr_q.push_back(32'h300);
        push_inst(32'h300);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("mis_clear", fetch_misaligned, 1'b0);
        wait_nout(9);
`else
        exp_addr_q.push_back(32'h100);
        push_inst(32'h100);
        imem_req_ready = 1'b1;
        wait_valid();
        chk("lowbits_pc", inst_pc, 32'h100);
        chk("lowbits_flag", fetch_misaligned, 1'b0);
        step();
        inst_ready = 1'b1;
        wait_nout(9);
`endif
        imem_req_ready = 1'b0;

        repeat (6) @(negedge clk);
        chk("addr_q_empty", exp_addr_q.size(), 0);
        chk("inst_q_empty", exp_inst_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
